// File: rtl/led_page_scanner_if.sv
// Board-side bundle for the debug page scanner: page select/readback from the datapath
// plus the multiplexed 7-segment pins.
interface led_page_scanner_if;
  logic        sel_btn;
  logic [15:0] Led_out;
  logic [1:0]  ledSel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    input  sel_btn,
    input  Led_out,
    output ledSel,
    output an,
    output seg,
    output dp
  );

  modport slave (
    output sel_btn,
    output Led_out,
    input  ledSel,
    input  an,
    input  seg,
    input  dp
  );
endinterface

// File: rtl/led_page_scanner.sv
// Selects one of four datapath debug pages, shadows the returned word and scans it out
// as four hex digits on an active-low multiplexed 7-segment display.
module led_page_scanner #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned SETTLE      = 2
) (
  input logic                clk,
  input logic                rst,
  led_page_scanner_if.master bus
);

  localparam int unsigned DivW = $clog2(REFRESH_DIV);
  localparam int unsigned SetW = $clog2(SETTLE + 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(REFRESH_DIV - 1);
  localparam logic [SetW-1:0] SettleLd = SetW'(SETTLE);

  logic            btn_q;
  logic [1:0]      page_q;
  logic [SetW-1:0] settle_q;
  logic [15:0]     shadow_q;
  logic [DivW-1:0] div_q;
  logic [1:0]      digit_q;
  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;

  logic       rise;
  logic       div_wrap;
  logic [3:0] nib;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign rise     = bus.sel_btn & ~btn_q;
  assign div_wrap = (div_q == DivLast);

  // Page select and capture: the shadow is frozen while the datapath settles on a new page.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= 1'b0;
      page_q   <= 2'd0;
      settle_q <= '0;
      shadow_q <= 16'h0000;
    end else begin
      btn_q <= bus.sel_btn;
      if (rise) begin
        page_q   <= page_q + 2'd1;
        settle_q <= SettleLd;
      end else if (settle_q != '0) begin
        settle_q <= settle_q - 1'b1;
      end else begin
        shadow_q <= bus.Led_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      digit_q <= 2'd0;
    end else if (div_wrap) begin
      div_q   <= '0;
      digit_q <= digit_q + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_comb begin
    nib   = shadow_q[{digit_q, 2'b00} +: 4];
    an_d  = ~(4'b0001 << digit_q);
    dp_d  = (digit_q != page_q);
    seg_d = 7'b1111111;
    unique case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
    endcase
  end

  // Registered pins keep segment and anode changes on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.ledSel = page_q;
  assign bus.an     = an_q;
  assign bus.seg    = seg_q;
  assign bus.dp     = dp_q;

endmodule

// File: tb/tb_led_page_scanner.sv
// Directed bench for led_page_scanner: expected pin states are queued per edge from the
// tracked shadow/page values and compared after each edge.
module tb_led_page_scanner;

  localparam int unsigned RefreshDiv = 4;
  localparam int unsigned Settle     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_page_scanner_if bus ();

  led_page_scanner #(
    .REFRESH_DIV(RefreshDiv),
    .SETTLE     (Settle)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] sel;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;   // edges since reset release
  logic [15:0] sh;          // shadow value before the next edge
  logic [1:0]  sel;         // page before the next edge

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard: got empty queue want an entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".an"},     16'(bus.an),     16'(e.an));
      chk({e.tag, ".seg"},    16'(bus.seg),    16'(e.seg));
      chk({e.tag, ".dp"},     16'(bus.dp),     16'(e.dp));
      chk({e.tag, ".ledSel"}, 16'(bus.ledSel), 16'(e.sel));
    end
  endtask

  // One non-reset edge: the pins show the digit selected before the edge.
  task automatic step(input string tag, input logic [15:0] sh_next, input logic [1:0] sel_next);
    exp_t       e;
    logic [1:0] d;
    logic [3:0] one;
    one   = 4'b0001;
    d     = 2'((cyc / 4) % 4);
    e.tag = tag;
    e.an  = ~(one << d);
    e.seg = hex7(sh[{d, 2'b00} +: 4]);
    e.dp  = (d != sel);
    e.sel = sel_next;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    pop_check();
    sh  = sh_next;
    sel = sel_next;
  endtask

  task automatic reset_step(input string tag);
    exp_t e;
    e.tag = tag;
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    e.sel = 2'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cyc = 0;
    pop_check();
    sh  = 16'h0000;
    sel = 2'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.sel_btn = 1'b0;
    bus.Led_out = 16'hBEEF;
    sh  = 16'h0000;
    sel = 2'd0;

    // Reset held for two edges.
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst.an",     16'(bus.an),     16'hF);
    chk("rst.seg",    16'(bus.seg),    16'h7F);
    chk("rst.dp",     16'(bus.dp),     16'h1);
    chk("rst.ledSel", 16'(bus.ledSel), 16'h0);
    rst = 1'b0;
    cyc = 0;
    step("rel_zero", 16'hBEEF, 2'd0);
    step("rel_beef", 16'hBEEF, 2'd0);

    // Full scan plus wrap of 1234.
    bus.Led_out = 16'h1234;
    step("pre_scan", 16'h1234, 2'd0);
    for (int i = 0; i < 16; i++) step("scan", 16'h1234, 2'd0);

    // Single pulse: page 1, shadow frozen for the rise edge plus two settle edges.
    bus.sel_btn = 1'b1;
    step("adv_rise", 16'h1234, 2'd1);
    bus.sel_btn = 1'b0;
    bus.Led_out = 16'hA5C3;
    step("adv_s1", 16'h1234, 2'd1);
    step("adv_s2", 16'h1234, 2'd1);
    step("adv_cap", 16'hA5C3, 2'd1);
    for (int i = 0; i < 16; i++) step("adv_scan", 16'hA5C3, 2'd1);

    // Held button advances once.
    bus.sel_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step("hold", (k >= 3) ? 16'h0F69 : 16'hA5C3, 2'd2);
      bus.Led_out = 16'h0F69;
    end
    bus.sel_btn = 1'b0;
    step("hold_rel", 16'h0F69, 2'd2);

    // Four pulses, crossing 3 -> 0.
    for (int p = 0; p < 4; p++) begin
      bus.sel_btn = 1'b1;
      step("pulse", 16'h0F69, sel + 2'd1);
      bus.sel_btn = 1'b0;
      step("gap", 16'h0F69, sel);
    end
    for (int i = 0; i < 3; i++) step("idle", 16'h0F69, sel);

    // Second rise during settle reloads the counter and delays capture.
    bus.sel_btn = 1'b1;
    step("b2b_r1", 16'h0F69, 2'd3);
    bus.sel_btn = 1'b0;
    bus.Led_out = 16'hD8B6;
    step("b2b_gap", 16'h0F69, 2'd3);
    bus.sel_btn = 1'b1;
    step("b2b_r2", 16'h0F69, 2'd0);
    bus.sel_btn = 1'b0;
    step("b2b_s1", 16'h0F69, 2'd0);
    step("b2b_s2", 16'h0F69, 2'd0);
    step("b2b_cap", 16'hD8B6, 2'd0);
    for (int i = 0; i < 4; i++) step("b2b_show", 16'hD8B6, 2'd0);

    // Reset while page 3, digit 2 and settle in flight.
    for (int p = 0; p < 2; p++) begin
      bus.sel_btn = 1'b1;
      step("mid_pulse", 16'hD8B6, sel + 2'd1);
      bus.sel_btn = 1'b0;
      step("mid_gap", 16'hD8B6, sel);
    end
    while ((((cyc + 1) / 4) % 4) != 2) step("align", 16'hD8B6, sel);
    bus.Led_out = 16'h5A5A;
    bus.sel_btn = 1'b1;
    step("pre_rst_rise", 16'hD8B6, 2'd3);
    bus.sel_btn = 1'b0;
    rst = 1'b1;
    reset_step("mid_rst");
    rst = 1'b0;
    step("rr_zero", 16'h5A5A, 2'd0);
    step("rr_cap", 16'h5A5A, 2'd0);
    for (int i = 0; i < 14; i++) step("rr_scan", 16'h5A5A, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
